instr_fetch: RTL and testbench

//  Fetch stage upstream of the instruction register: owns the program counter, runs a
//  req/ack read handshake to instruction memory, and drives IR data with a 1-cycle load

---
 rtl/s_proc_pkg.sv | 23 ++
 rtl/pc_unit.sv | 25 ++
 rtl/instr_fetch.sv | 179 +++++++++++++++++
 tb/tb_instr_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_proc_pkg.sv
// Shared fetch-stage types and defaults: bus widths, reset PC, fetch state encoding.
package s_proc_pkg;

    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
    localparam int unsigned TIMEOUT_CYC_DEF = 15;

    localparam logic [2:0] FS_IDLE  = 3'd0;
    localparam logic [2:0] FS_BUSY  = 3'd1;
    localparam logic [2:0] FS_FLUSH = 3'd2;
    localparam logic [2:0] FS_HOLD  = 3'd3;
    localparam logic [2:0] FS_ERR   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = FS_IDLE,
        S_BUSY  = FS_BUSY,
        S_FLUSH = FS_FLUSH,
        S_HOLD  = FS_HOLD,
        S_ERR   = FS_ERR
    } fetch_state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter: loads a redirect target or steps by one, wrapping at 2^ADDR_W.
// Latency 1 cycle; load wins over increment, no backpressure.
module pc_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: req/ack reads from instruction memory, one-word hold buffer, redirects, timeout.
// Latency: ack at edge N gives ir_ce in cycle N+1; stall parks the word in the hold buffer.
module instr_fetch
    import s_proc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] ir_d,
    output logic              ir_ce,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_err
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    fetch_state_t      state, state_nxt;
    logic              mem_req_nxt, ir_ce_nxt, fetch_err_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt, pc_out_nxt, hold_pc, hold_pc_nxt, pc;
    logic [DATA_W-1:0] ir_d_nxt, hold_dat, hold_dat_nxt;
    logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nxt;
    logic              pc_inc, pc_load, tmo_tick;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk     (clk),
        .rst     (rst),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            ir_d      <= '0;
            ir_ce     <= 1'b0;
            pc_out    <= '0;
            fetch_err <= 1'b0;
            tmo_cnt   <= '0;
            hold_dat  <= '0;
            hold_pc   <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= mem_req_nxt;
            mem_addr  <= mem_addr_nxt;
            ir_d      <= ir_d_nxt;
            ir_ce     <= ir_ce_nxt;
            pc_out    <= pc_out_nxt;
            fetch_err <= fetch_err_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            hold_dat  <= hold_dat_nxt;
            hold_pc   <= hold_pc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_addr_nxt  = mem_addr;
        ir_d_nxt      = ir_d;
        ir_ce_nxt     = 1'b0;
        pc_out_nxt    = pc_out;
        fetch_err_nxt = fetch_err;
        tmo_cnt_nxt   = tmo_cnt;
        hold_dat_nxt  = hold_dat;
        hold_pc_nxt   = hold_pc;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        tmo_tick      = 1'b0;

        if (redirect) begin
            // An in-flight read cannot be cancelled on the bus, so it is drained in S_FLUSH.
            pc_load = 1'b1;
            case (state)
                S_BUSY: begin
                    if (mem_ack) begin
                        mem_req_nxt = 1'b0;
                        state_nxt   = S_IDLE;
                    end else begin
                        tmo_cnt_nxt = '0;
                        state_nxt   = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (mem_ack) begin
                        mem_req_nxt = 1'b0;
                        state_nxt   = S_IDLE;
                    end else begin
                        tmo_tick = 1'b1;
                    end
                end
                default: begin
                    fetch_err_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (!stall) begin
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = pc;
                        tmo_cnt_nxt  = '0;
                        state_nxt    = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        mem_req_nxt = 1'b0;
                        pc_inc      = 1'b1;
                        if (!stall) begin
                            ir_d_nxt   = mem_rdata;
                            pc_out_nxt = mem_addr;
                            ir_ce_nxt  = 1'b1;
                            state_nxt  = S_IDLE;
                        end else begin
                            hold_dat_nxt = mem_rdata;
                            hold_pc_nxt  = mem_addr;
                            state_nxt    = S_HOLD;
                        end
                    end else begin
                        tmo_tick = 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (mem_ack) begin
                        mem_req_nxt = 1'b0;
                        state_nxt   = S_IDLE;
                    end else begin
                        tmo_tick = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ir_d_nxt   = hold_dat;
                        pc_out_nxt = hold_pc;
                        ir_ce_nxt  = 1'b1;
                        state_nxt  = S_IDLE;
                    end
                end
                S_ERR: begin
                    state_nxt = S_ERR;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        if (tmo_tick) begin
            if (tmo_cnt == TMO_LAST) begin
                mem_req_nxt   = 1'b0;
                fetch_err_nxt = 1'b1;
                state_nxt     = S_ERR;
            end else begin
                tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: behavioural memory + fetch model feeding a scoreboard.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] ir_d;
    logic        ir_ce;
    logic [15:0] pc_out;
    logic        fetch_err;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .RESET_PC    (16'h0000),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .ir_d        (ir_d),
        .ir_ce       (ir_ce),
        .pc_out      (pc_out),
        .fetch_err   (fetch_err)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] dat;
        int          due;
    } exp_t;

    exp_t ir_q[$];
    exp_t addr_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: what the fetch stage should be doing, in plain terms.
    logic [15:0] m_pc = '0, cur_addr = '0, held_addr = '0, held_dat = '0;
    bit          req_open = 0, flushed = 0, held = 0, err = 0;
    int          age = 0, ack_wait = 0;

    // Stimulus knobs and one-shot directed hooks.
    int unsigned p_stall = 0, p_redir = 0;
    int          ack_min = 1, ack_max = 1;
    bit          no_ack = 0, force_redir = 0;
    logic [15:0] force_tgt = '0, hook_flush_tgt = '0, hook_ackr_tgt = '0;
    int          hook_stall_addr = -1, hook_flush_addr = -1, hook_ackr_addr = -1;
    int          stall_hold = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_ir(input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.addr = a; e.dat = d; e.due = cyc + 1;
        ir_q.push_back(e);
    endtask

    task automatic wait_tick();
        age++;
        if (age >= 15) begin
            req_open = 0;
            err      = 1;
        end
    endtask

    task automatic model(input bit st, input bit rd, input logic [15:0] tgt,
                         input bit a, input logic [15:0] dat);
        exp_t e;
        if (rd) begin
            m_pc = tgt; held = 0; err = 0;
            if (req_open) begin
                if (a) req_open = 0;
                else if (!flushed) begin flushed = 1; age = 0; end
                else wait_tick();
            end
        end else if (req_open) begin
            if (a) begin
                req_open = 0;
                if (!flushed) begin
                    m_pc = m_pc + 16'd1;
                    if (!st) push_ir(cur_addr, dat);
                    else begin held = 1; held_addr = cur_addr; held_dat = dat; end
                end
            end else begin
                wait_tick();
            end
        end else if (held) begin
            if (!st) begin push_ir(held_addr, held_dat); held = 0; end
        end else if (!err && !st) begin
            req_open = 1; flushed = 0; age = 0; cur_addr = m_pc;
            ack_wait = int'($urandom_range(ack_max, ack_min));
            e.addr = m_pc; e.dat = '0; e.due = cyc + 1;
            addr_q.push_back(e);
        end
    endtask

    task automatic run(input int n);
        bit          a, rd, st;
        logic [15:0] tgt, dat;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("mem_req", mem_req, req_open);
            check("fetch_err", fetch_err, err);
            a = 1'b0;
            if (req_open) begin
                if (!no_ack) begin
                    if (ack_wait == 0) a = 1'b1;
                    else ack_wait--;
                end
            end else begin
                a = ($urandom_range(0, 1) == 1);
            end
            rd  = 1'b0;
            tgt = 16'($urandom);
            if (force_redir) begin
                rd = 1'b1; tgt = force_tgt; force_redir = 0;
            end else if (req_open && !flushed && !a && hook_flush_addr == int'(cur_addr)) begin
                rd = 1'b1; tgt = hook_flush_tgt; hook_flush_addr = -1;
            end else if (req_open && !flushed && a && hook_ackr_addr == int'(cur_addr)) begin
                rd = 1'b1; tgt = hook_ackr_tgt; hook_ackr_addr = -1;
            end else if ($urandom_range(0, 99) < p_redir) begin
                rd = 1'b1;
                if ($urandom_range(0, 3) == 0) tgt = 16'hFFFE;
            end
            if (stall_hold > 0) begin
                st = 1'b1; stall_hold--;
            end else if (req_open && !flushed && a && !rd && hook_stall_addr == int'(cur_addr)) begin
                st = 1'b1; stall_hold = 3; hook_stall_addr = -1;
            end else begin
                st = ($urandom_range(0, 99) < p_stall);
            end
            dat = (req_open && cur_addr == 16'h0005) ? 16'hA5A5 : 16'($urandom);
            stall = st; redirect = rd; redirect_pc = tgt; mem_ack = a; mem_rdata = dat;
            model(st, rd, tgt, a, dat);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request or an instruction.
    logic        prev_req = 1'b0, prev_ce = 1'b0;
    logic [15:0] prev_addr = '0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            prev_req = 1'b0;
            prev_ce  = 1'b0;
        end else begin
            if (ir_ce) begin
                check("ir_ce_back_to_back", prev_ce, 1'b0);
                if (ir_q.size() == 0) begin
                    check("ir_ce_unexpected", ir_ce, 1'b0);
                end else begin
                    e = ir_q.pop_front();
                    check("ir_d", ir_d, e.dat);
                    check("pc_out", pc_out, e.addr);
                    check("ir_latency", cyc, e.due);
                end
            end else if (ir_q.size() > 0 && ir_q[0].due <= cyc) begin
                check("ir_ce_missing", ir_ce, 1'b1);
                e = ir_q.pop_front();
            end
            if (mem_req && !prev_req) begin
                if (addr_q.size() == 0) begin
                    check("mem_req_unexpected", mem_req, 1'b0);
                end else begin
                    e = addr_q.pop_front();
                    check("mem_addr", mem_addr, e.addr);
                    check("req_latency", cyc, e.due);
                end
            end else if (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
                check("mem_req_missing", mem_req && !prev_req, 1'b1);
                e = addr_q.pop_front();
            end
            if (mem_req && prev_req) check("mem_addr_stable", mem_addr, prev_addr);
            prev_req  = mem_req;
            prev_addr = mem_addr;
            prev_ce   = ir_ce;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && (req_open || held); i++) run(1);
        check("reached_idle", {30'd0, req_open, held}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_ir_d", ir_d, 16'h0000);
        check("rst_ir_ce", ir_ce, 1'b0);
        check("rst_pc_out", pc_out, 16'h0000);
        check("rst_fetch_err", fetch_err, 1'b0);
        #2 rst = 1'b1;

        // Straight-line fetch, ack in the second request cycle.
        run(12);
        // Decode stalls as address 5 is acknowledged.
        hook_stall_addr = 5;
        run(25);
        // Redirect mid-read at address 7, then redirect coinciding with ack at 0x42.
        ack_min = 2; ack_max = 2;
        hook_flush_addr = 7;     hook_flush_tgt = 16'h0040;
        hook_ackr_addr  = 16'h42; hook_ackr_tgt = 16'h0080;
        run(45);
        // Wrap from 0xFFFF to 0x0000.
        ack_min = 1; ack_max = 1;
        force_redir = 1; force_tgt = 16'hFFFE;
        run(20);
        // Memory never answers: timeout, sticky error, cleared by redirect.
        wait_idle();
        no_ack = 1; force_redir = 1; force_tgt = 16'h0100;
        run(25);
        check("timeout_err_set", fetch_err, 1'b1);
        check("timeout_req_low", mem_req, 1'b0);
        run(3);
        check("timeout_err_sticky", fetch_err, 1'b1);
        no_ack = 0; force_redir = 1; force_tgt = 16'h0010;
        run(2);
        check("timeout_err_cleared", fetch_err, 1'b0);
        run(10);

        // Random traffic: short acks, then long acks that sometimes time out.
        p_stall = 30; p_redir = 4; ack_min = 0; ack_max = 4;
        run(3000);
        p_redir = 6; ack_max = 20;
        run(2000);

        // Asynchronous reset while a request is on the bus.
        p_redir = 0; p_stall = 0; ack_min = 3; ack_max = 3;
        for (int i = 0; i < 40 && !req_open; i++) run(1);
        run(1);
        check("pre_reset_req_high", mem_req, 1'b1);
        #2 rst = 1'b0;
        stall = 1'b1; redirect = 1'b0; mem_ack = 1'b0;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_ce", ir_ce, 1'b0);
        check("async_rst_addr", mem_addr, 16'h0000);
        m_pc = '0; req_open = 0; flushed = 0; held = 0; err = 0;
        stall_hold = 0; force_redir = 0;
        ir_q.delete(); addr_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        ack_min = 1; ack_max = 1;
        run(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
